// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module  : multiplier
// Brief   : Signed radix-4 Booth multiplier, adder tree, >>> rescale, 0..3 stages
// Rev     : 1.0
// ============================================================================
module multiplier #(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 10,
  parameter int OUT_WIDTH = A_WIDTH,
  parameter int FRAC_BITS = 0,
  parameter int LATENCY   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 valid_in,
  output logic [OUT_WIDTH-1:0] p,
  output logic                 valid_out
);

  localparam int c_W   = A_WIDTH + B_WIDTH;
  localparam int c_NPP = (B_WIDTH + 2) / 2;

  function automatic int f_cnt(input int lvl);
    int n;
    n = c_NPP;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int f_nlev(input int npp);
    int n;
    int l;
    n = npp;
    l = 0;
    while (n > 1) begin
      n = (n + 1) / 2;
      l++;
    end
    return l;
  endfunction

  localparam int c_NLEV  = f_nlev(c_NPP);
  localparam int c_EXTRA = (LATENCY > c_NLEV + 1) ? (LATENCY - c_NLEV - 1) : 0;
  localparam int c_SW    = (c_W > OUT_WIDTH) ? c_W : OUT_WIDTH;

  logic [c_W-1:0]     w_a_ext;
  logic [2*c_NPP:0]   w_bext;
  logic [c_W-1:0]     w_node [0:c_NLEV][0:c_NPP-1];
  logic [c_W-1:0]     w_q    [0:c_NLEV][0:c_NPP-1];

  assign w_a_ext = c_W'($signed(a));
  assign w_bext  = {{(2*c_NPP-B_WIDTH){b[B_WIDTH-1]}}, b, 1'b0};

  // Each digit looks at b[2i+1], b[2i], b[2i-1] and selects 0, +-a or +-2a.
  for (genvar i = 0; i < c_NPP; i++) begin : g_booth
    logic [2:0]     w_dig;
    logic [c_W-1:0] w_mag;
    assign w_dig = w_bext[2*i+2 -: 3];
    always_comb begin
      w_mag = '0;
      case (w_dig)
        3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_a_ext;
        3'b011, 3'b100:                 w_mag = {w_a_ext[c_W-2:0], 1'b0};
        default:                        w_mag = '0;
      endcase
    end
    assign w_node[0][i] = (w_dig[2] ? (~w_mag + 1'b1) : w_mag) << (2*i);
  end

  // Level 0 holds the Booth terms; level l+1 pairs up level l. A stage register
  // sits at the boundary of every level below LATENCY.
  for (genvar l = 0; l <= c_NLEV; l++) begin : g_lvl
    for (genvar j = 0; j < c_NPP; j++) begin : g_node
      if (j >= f_cnt(l)) begin : g_idle
        assign w_q[l][j] = '0;
        if (l > 0) begin : g_idle_in
          assign w_node[l][j] = '0;
        end
      end else begin : g_live
        if (l > 0) begin : g_sum
          if (2*j+1 < f_cnt(l-1)) begin : g_add
            assign w_node[l][j] = w_q[l-1][2*j] + w_q[l-1][2*j+1];
          end else begin : g_pass
            assign w_node[l][j] = w_q[l-1][2*j];
          end
        end
        if (l < LATENCY) begin : g_reg
          logic [c_W-1:0] r_pp;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_pp <= '0;
            else     r_pp <= w_node[l][j];
          end
          assign w_q[l][j] = r_pp;
        end else begin : g_wire
          assign w_q[l][j] = w_node[l][j];
        end
      end
    end
  end

  logic signed [c_SW-1:0] w_full;
  logic signed [c_SW-1:0] w_scaled;
  logic [OUT_WIDTH-1:0]   w_res;

  assign w_full   = c_SW'($signed(w_q[c_NLEV][0]));
  assign w_scaled = w_full >>> FRAC_BITS;
  assign w_res    = w_scaled[OUT_WIDTH-1:0];

  if (c_EXTRA == 0) begin : g_no_extra
    assign p = w_res;
  end else begin : g_extra
    logic [OUT_WIDTH-1:0] r_out [0:c_EXTRA-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < c_EXTRA; k++) r_out[k] <= '0;
      end else begin
        r_out[0] <= w_res;
        for (int k = 1; k < c_EXTRA; k++) r_out[k] <= r_out[k-1];
      end
    end
    assign p = r_out[c_EXTRA-1];
  end

  if (LATENCY == 0) begin : g_vcomb
    assign valid_out = valid_in;
  end else begin : g_vpipe
    logic [LATENCY-1:0] r_vsr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vsr <= '0;
      else     r_vsr <= (r_vsr << 1) | LATENCY'(valid_in);
    end
    assign valid_out = r_vsr[LATENCY-1];
  end

  // Upper bits of the rescaled product are discarded by design; clk/rst are idle at LATENCY 0.
  logic w_unused;
  assign w_unused = ^{clk, rst, w_scaled};

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier
// Brief   : Directed and random checks of multiplier across widths, scaling, latency
// Rev     : 1.0
// ============================================================================
module tb_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  a, b;
  logic        v_c;
  logic [9:0]  p_def, p_fx;
  logic [19:0] p_w20;
  logic        vo_def, vo_w20, vo_fx;

  logic [9:0]  a2, b2, p2;
  logic        vi2, vo2;

  multiplier u_def (
    .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(v_c), .p(p_def), .valid_out(vo_def));
  multiplier #(.OUT_WIDTH(20)) u_w20 (
    .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(v_c), .p(p_w20), .valid_out(vo_w20));
  multiplier #(.FRAC_BITS(8)) u_fx (
    .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(v_c), .p(p_fx), .valid_out(vo_fx));
  multiplier #(.LATENCY(2)) u_pipe (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .valid_in(vi2), .p(p2), .valid_out(vo2));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] p;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] msk(input longint v, input int ow);
    return 32'(v) & ((32'd1 << ow) - 32'd1);
  endfunction

  // Reference: exact signed product, arithmetic shift, keep the low OW bits.
  function automatic logic [31:0] ref_p(input logic [9:0] ai, input logic [9:0] bi,
                                        input int frac, input int ow);
    longint f;
    f = longint'($signed(ai)) * longint'($signed(bi));
    f = f >>> frac;
    return msk(f, ow);
  endfunction

  function automatic logic [9:0] rnd10();
    case ($urandom_range(0, 7))
      0:       return 10'h200;
      1:       return 10'h1FF;
      2:       return 10'h3FF;
      default: return 10'($urandom);
    endcase
  endfunction

  task automatic drive_pipe(input logic [9:0] ai, input logic [9:0] bi, input logic vi);
    a2  = ai;
    b2  = bi;
    vi2 = vi;
    if (vi) sb.push_back('{p: ref_p(ai, bi, 0, 10), due: cyc + 2});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every presented result must match the oldest outstanding expectation
  // and arrive in exactly the cycle it is due.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (vo2) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL pipe_unexpected: valid_out=1 p=0x%0h, expected no result", p2);
      end else begin
        e = sb.pop_front();
        check("pipe_p", 32'(p2), e.p);
        check("pipe_due", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      $display("FAIL pipe_missing: valid_out=0 at cycle %0d, expected result 0x%0h", cyc, e.p);
    end
  end

  int bv [6] = '{0, 1, 255, -1, -512, 511};
  int ca [3] = '{-512, 511, -1};
  int cb [3] = '{-512, -512, -1};
  int ce [3] = '{262144, -261632, 1};

  initial begin
    a = 10'd3; b = 10'($signed(-5)); v_c = 1'b0;
    a2 = '0; b2 = '0; vi2 = 1'b0;
    #12;
    check("rst_pipe_p", 32'(p2), 0);
    check("rst_pipe_vo", 32'(vo2), 0);
    check("rst_comb_p", 32'(p_def), msk(-15, 10));
    @(negedge clk);
    rst = 1'b0;

    a = 10'd1;
    foreach (bv[i]) begin
      b = 10'(bv[i]); v_c = i[0]; #1;
      check("ident_p", 32'(p_def), msk(bv[i], 10));
      check("ident_vo", 32'(vo_def), 32'(i[0]));
    end
    foreach (ca[i]) begin
      a = 10'(ca[i]); b = 10'(cb[i]); #1;
      check("corner_w20", 32'(p_w20), msk(ce[i], 20));
    end
    a = 10'd100; b = 10'd100; #1;
    check("trunc_784", 32'(p_def), 32'd784);
    a = 10'($signed(-3)); b = 10'd5; #1;
    check("trunc_neg15", 32'(p_def), 32'h3F1);
    a = 10'd77; b = 10'd200; #1;
    check("fx_pos", 32'(p_fx), 32'd60);
    a = 10'($signed(-43)); b = 10'd100; #1;
    check("fx_neg", 32'(p_fx), msk(-17, 10));

    for (int i = 0; i < 300; i++) begin
      a = rnd10(); b = rnd10(); v_c = 1'($urandom); #1;
      check("rnd_def", 32'(p_def), ref_p(a, b, 0, 10));
      check("rnd_w20", 32'(p_w20), ref_p(a, b, 0, 20));
      check("rnd_fx", 32'(p_fx), ref_p(a, b, 8, 10));
      check("rnd_vo", 32'({vo_def, vo_w20, vo_fx}), {29'd0, {3{v_c}}});
    end

    @(posedge clk); #1;
    for (int i = 0; i < 10000; i++) begin
      drive_pipe(rnd10(), rnd10(), 1'b1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      drive_pipe(rnd10(), rnd10(), 1'b1);
      @(posedge clk); #1;
    end

    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_p", 32'(p2), 0);
    check("midrst_vo", 32'(vo2), 0);
    drive_pipe(rnd10(), rnd10(), 1'b0);
    @(posedge clk); #1;
    check("rsthold_p", 32'(p2), 0);
    rst = 1'b0;
    #1;
    check("release_p", 32'(p2), 0);
    @(posedge clk); #1;
    check("post_rst_p", 32'(p2), 0);
    check("post_rst_vo", 32'(vo2), 0);
    for (int i = 0; i < 40; i++) begin
      drive_pipe(rnd10(), rnd10(), 1'($urandom_range(0, 3) != 0));
      @(posedge clk); #1;
    end
    drive_pipe('0, '0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pipe_drain", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier.md
# multiplier

Parameterized signed two's-complement multiplier for the constant-coefficient datapaths (colour-space transform, products-sum trees). Multiplies a coefficient operand by a data operand, optionally rescales for fixed-point coefficients, truncates to the output width, and offers zero or more pipeline stages. It is built as radix-4 Booth partial-product generation plus an adder tree, not a behavioural `*`.

## Interface
- `A_WIDTH`, default 10: coefficient operand width (signed).
- `B_WIDTH`, default 10: data operand width (signed).
- `OUT_WIDTH`, default `A_WIDTH`: product output width.
- `FRAC_BITS`, default 0: arithmetic right shift applied to the full product before truncation.
- `LATENCY`, default 0: number of pipeline register stages, range 0..3. At 0 the block is purely combinational.

Ports:
- `clk`, input, 1: clock. All registers use the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `a`, input, `A_WIDTH`: signed coefficient.
- `b`, input, `B_WIDTH`: signed data.
- `valid_in`, input, 1: operands valid.
- `p`, output, `OUT_WIDTH`: result.
- `valid_out`, output, 1: `valid_in` delayed by `LATENCY` cycles.

## Operation
- Full product: `full = a * b`, signed, `A_WIDTH+B_WIDTH` bits, exact. Covers the most-negative × most-negative case.
- Partial products:
  - Radix-4 Booth recoding of `b`, giving ceil((B_WIDTH+1)/2) partial products.
  - Each partial product is one of 0, ±a, ±2a, sign-extended to the full width.
  - Partial products are summed by a binary adder tree. An odd leftover operand is passed to the next level unchanged.
- Scaling: `scaled = full >>> FRAC_BITS`. This is arithmetic and truncates toward −∞; there is no rounding.
- Output: `p = scaled[OUT_WIDTH-1:0]`. This is wrap-around truncation with no saturation. An overflow discards the upper bits silently.
- `valid_in` has no effect on the arithmetic. `p` is computed every cycle regardless of valid.
- Pipeline placement:
  - With `LATENCY` ≥ 1, registers sit after Booth recoding and then after successive tree levels. Any stages left over are added at the output.
  - Pipeline data registers and the valid shift register are reset to 0 by `rst`.

## Timing
- `LATENCY` = 0:
  - `p` follows `a`/`b` combinationally.
  - `valid_out` = `valid_in`.
  - `clk` and `rst` are unused.
- `LATENCY` = N:
  - Operands sampled at edge k appear on `p` after edge k+N−1, i.e. N cycles later.
  - `valid_out` matches that alignment exactly.
- Throughput: one operation per cycle, fully pipelined, no stalls.
- Reset:
  - Asserting `rst` immediately forces all stage registers, `p` and `valid_out` to 0, even mid-pipeline.
  - In-flight results are lost.
  - After deassertion, `p` = 0 until the first post-reset operands emerge N cycles later.
  - With `LATENCY` = 0, reset has no effect on `p`.
- Back-to-back operand changes each cycle produce back-to-back results with no bubbles.

## Test plan
- Identity, defaults (10/10/10, LATENCY 0): a=1, b ∈ {0, 1, 255, −1, −512, 511} → p = b exactly, combinational.
- Signed corners, OUT_WIDTH=20: a=−512, b=−512 → p=262144; a=511, b=−512 → p=−261632; a=−1, b=−1 → p=1.
- Truncation, defaults: a=100, b=100 → p = 10000 mod 1024 = 784 (10'h310). a=−3, b=5 → p=−15 (10'h3F1).
- Fixed point, FRAC_BITS=8, OUT_WIDTH=10: a=77 (0.299·256), b=200 → full 15400 → p=60. a=−43, b=100 → full −4300 → p=−17.
- Pipeline, LATENCY=2: a new operand pair with `valid_in`=1 each cycle → each `p` appears exactly 2 cycles later with `valid_out`=1. Compare against a reference model over 10 000 random operands.
- Reset mid-stream, LATENCY=2: assert `rst` between edges while valid data is in flight → `p`=0 and `valid_out`=0 immediately. After release, the first valid result appears 2 cycles after the first new `valid_in`.
